// File: rtl/mcu_spi_pkg.sv
// rtl/mcu_spi_pkg.sv - shared types and constants for the MCU companion SPI master
package mcu_spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    HOLD,
    GAP
  } spi_state_e;

  // Companion command opcodes understood by the core's MCU responder
  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_READ_REG  = 8'h01;
  localparam logic [7:0] OP_WRITE_REG = 8'h02;
  localparam logic [7:0] OP_STATUS    = 8'h05;

endpackage

// File: rtl/mcu_spi_if.sv
// rtl/mcu_spi_if.sv - byte-stream front end between a controller and the SPI master
interface mcu_spi_if;
  import mcu_spi_pkg::*;

  logic [SPI_BITS-1:0] tx_data;
  logic                tx_last;
  logic                tx_valid;
  logic                tx_ready;
  logic [SPI_BITS-1:0] rx_data;
  logic                rx_valid;

  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/mcu_spi_sync.sv
// rtl/mcu_spi_sync.sv - two-flop synchroniser with configurable reset value
module mcu_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mcu_spi_master.sv
// rtl/mcu_spi_master.sv - mode-0 SPI master driving the core's MCU port from on-chip logic
module mcu_spi_master
  import mcu_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  mcu_spi_if.slave bus,
  output logic     busy,
  output logic     irq,
  output logic     mcu_sclk,
  output logic     mcu_csn,
  output logic     mcu_mosi,
  input  logic     mcu_miso,
  input  logic     mcu_intn
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);
  localparam logic [3:0]    BIT_END = 4'(2 * SPI_BITS - 1);

  spi_state_e  state;
  logic [CW-1:0] div_cnt;
  logic [3:0]  bit_cnt;
  logic [6:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic        last_q;
  logic        intn_s;
  logic        accept;
  logic        div_end;

  assign accept  = bus.tx_valid && bus.tx_ready;
  assign div_end = (div_cnt == DIV_END);
  assign busy    = (state != IDLE);
  assign irq     = ~intn_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      last_q       <= 1'b0;
      mcu_sclk     <= 1'b0;
      mcu_csn      <= 1'b1;
      mcu_mosi     <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.tx_ready <= 1'b1;
    end else begin
      bus.rx_valid <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (accept) begin
            state        <= SHIFT;
            mcu_csn      <= 1'b0;
            mcu_mosi     <= bus.tx_data[7];
            tx_sr        <= bus.tx_data[6:0];
            last_q       <= bus.tx_last;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bus.tx_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt  <= '0;
            mcu_sclk <= ~mcu_sclk;
            bit_cnt  <= bit_cnt + 4'd1;
            // Even edge counts are rising edges (sample), odd ones falling (launch)
            if (!bit_cnt[0]) begin
              rx_sr <= {rx_sr[6:0], mcu_miso};
            end else begin
              mcu_mosi <= tx_sr[6];
              tx_sr    <= {tx_sr[5:0], 1'b0};
            end
            if (bit_cnt == BIT_END) begin
              bus.rx_data  <= rx_sr;
              bus.rx_valid <= 1'b1;
              state        <= last_q ? HOLD : WAIT;
              bus.tx_ready <= ~last_q;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        HOLD: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= GAP;
            mcu_csn <= 1'b1;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        GAP: begin
          if (div_cnt == GAP_END) begin
            div_cnt      <= '0;
            state        <= IDLE;
            bus.tx_ready <= 1'b1;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mcu_spi_sync #(.RST_VAL(1'b1)) u_intn_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (mcu_intn),
    .q       (intn_s)
  );

endmodule

// File: tb/tb_mcu_spi_master.sv
// tb/tb_mcu_spi_master.sv - self-checking bench for mcu_spi_master
module tb_mcu_spi_master;
  import mcu_spi_pkg::*;

  localparam int D = 2;
  localparam int G = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset_n, intn, loopback, resp_miso;
  logic busy, irq, sclk, csn, mosi, miso;
  logic busy1, irq1, sclk1, csn1, mosi1;

  mcu_spi_if bus ();
  mcu_spi_if bus1 ();

  assign miso = loopback ? mosi : resp_miso;

  mcu_spi_master #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .irq(irq),
    .mcu_sclk(sclk), .mcu_csn(csn), .mcu_mosi(mosi), .mcu_miso(miso), .mcu_intn(intn)
  );

  mcu_spi_master #(.CLK_DIV(1), .CS_GAP(G)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .busy(busy1), .irq(irq1),
    .mcu_sclk(sclk1), .mcu_csn(csn1), .mcu_mosi(mosi1), .mcu_miso(mosi1), .mcu_intn(1'b1)
  );

  // Responder model: presents a queued byte MSB first, captures what it receives
  logic [7:0] resp_q[$];
  logic [7:0] resp_got[$];
  logic [7:0] resp_sr, resp_cap;
  int resp_bits;

  always @(negedge csn) begin
    resp_bits = 0;
    if (resp_q.size() > 0) resp_sr = resp_q.pop_front();
    resp_miso = resp_sr[7];
  end

  always @(posedge sclk) if (!csn) begin
    resp_cap = {resp_cap[6:0], mosi};
    resp_bits++;
    if (resp_bits % 8 == 0) resp_got.push_back(resp_cap);
  end

  always @(negedge sclk) if (!csn) begin
    if (resp_bits % 8 == 0) begin
      if (resp_q.size() > 0) resp_sr = resp_q.pop_front();
    end else begin
      resp_sr = {resp_sr[6:0], 1'b0};
    end
    resp_miso = resp_sr[7];
  end

  // Event log, sampled 1 time unit after each active edge
  int acc_t[$], fall_t[$], rise_t[$], sclk_t[$], rdy_t[$], rxv_t[$];
  logic [7:0] rxv_d[$];
  int acc1_t[$], rxv1_t[$];
  logic [7:0] rxv1_d[$];
  logic p_csn = 1'b1, p_sclk = 1'b0, p_rdy = 1'b1, p_rdy1 = 1'b1;

  always @(posedge clk) begin
    #1;
    if (bus.tx_valid && p_rdy) acc_t.push_back(cyc - 1);
    if (p_csn && !csn) fall_t.push_back(cyc);
    if (!p_csn && csn) rise_t.push_back(cyc);
    if (!p_sclk && sclk) sclk_t.push_back(cyc);
    if (!p_rdy && bus.tx_ready) rdy_t.push_back(cyc);
    if (bus.rx_valid) begin rxv_t.push_back(cyc); rxv_d.push_back(bus.rx_data); end
    if (bus1.tx_valid && p_rdy1) acc1_t.push_back(cyc - 1);
    if (bus1.rx_valid) begin rxv1_t.push_back(cyc); rxv1_d.push_back(bus1.rx_data); end
    p_csn  = csn;
    p_sclk = sclk;
    p_rdy  = bus.tx_ready;
    p_rdy1 = bus1.tx_ready;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    acc_t.delete(); fall_t.delete(); rise_t.delete(); sclk_t.delete();
    rdy_t.delete(); rxv_t.delete(); rxv_d.delete(); resp_got.delete();
    acc1_t.delete(); rxv1_t.delete(); rxv1_d.delete();
  endtask

  // Call at a negedge; returns at the negedge just after the accepting edge
  task automatic put_byte(input logic [7:0] d, input logic last);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_last  = last;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_timeout", bus.tx_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic idle_wait();
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_accept();
    int n = 0;
    while (acc_t.size() == 0 && n < 100) begin @(negedge clk); n++; end
  endtask

  initial begin
    int t;
    int n;
    logic [7:0] x, r1, b1, b2;

    reset_n = 1'b0; intn = 1'b1; loopback = 1'b1; resp_miso = 1'b0;
    resp_sr = '0; resp_cap = '0; resp_bits = 0;
    bus.tx_data = '0; bus.tx_last = 1'b0; bus.tx_valid = 1'b0;
    bus1.tx_data = '0; bus1.tx_last = 1'b0; bus1.tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_sclk", sclk, 1'b0);
    chk("rst_csn", csn, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_tx_ready", bus.tx_ready, 1'b1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-byte loopback frame, full timing
    clear_log();
    put_byte(8'hA5, 1'b1);
    bus.tx_valid = 1'b0;
    chk("A_busy", busy, 1'b1);
    idle_wait();
    t = (acc_t.size() > 0) ? acc_t[0] : -1000;
    chk("A_csn_fall", fall_t[0], t + 1);
    chk("A_sclk_rise0", sclk_t[0], t + 1 + D);
    chk("A_sclk_rises", sclk_t.size(), 8);
    chk("A_rxv_time", rxv_t[0], t + 1 + 16 * D);
    chk("A_rxv_count", rxv_t.size(), 1);
    chk("A_rx_data", rxv_d[0], 8'hA5);
    chk("A_csn_rise", rise_t[0], t + 1 + 17 * D);
    chk("A_ready_back", rdy_t[0], t + 1 + 17 * D + G);
    chk("A_resp_rx", resp_got[0], 8'hA5);

    // Random loopback bytes
    for (int i = 0; i < 3; i++) begin
      clear_log();
      x = 8'($urandom);
      put_byte(x, 1'b1);
      bus.tx_valid = 1'b0;
      idle_wait();
      chk("B_rx_data", rxv_d[0], x);
      chk("B_resp_rx", resp_got[0], x);
    end

    // Responder-driven miso across a two-byte frame
    clear_log();
    loopback = 1'b0;
    r1 = 8'($urandom);
    resp_q.delete();
    resp_q.push_back(8'h3C);
    resp_q.push_back(r1);
    put_byte(8'hFF, 1'b0);
    put_byte(8'h00, 1'b1);
    bus.tx_valid = 1'b0;
    idle_wait();
    loopback = 1'b1;
    chk("C_rx0", rxv_d[0], 8'h3C);
    chk("C_rx1", rxv_d[1], r1);
    chk("C_csn_falls", fall_t.size(), 1);
    chk("C_csn_rises", rise_t.size(), 1);
    chk("C_sclk_rises", sclk_t.size(), 16);
    chk("C_resp_rx0", resp_got[0], 8'hFF);
    chk("C_resp_rx1", resp_got[1], 8'h00);

    // Three bytes with tx_valid held high throughout
    clear_log();
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    put_byte(OP_READ_REG, 1'b0);
    put_byte(b1, 1'b0);
    put_byte(b2, 1'b1);
    bus.tx_valid = 1'b0;
    idle_wait();
    t = (acc_t.size() > 0) ? acc_t[0] : -1000;
    chk("D_accepts", acc_t.size(), 3);
    chk("D_accept1", acc_t[1], t + 16 * D + 1);
    chk("D_accept2", acc_t[2], t + 2 * (16 * D + 1));
    chk("D_csn_falls", fall_t.size(), 1);
    chk("D_sclk_rises", sclk_t.size(), 24);
    chk("D_rx0", rxv_d[0], OP_READ_REG);
    chk("D_rx1", rxv_d[1], b1);
    chk("D_rx2", rxv_d[2], b2);

    // Interrupt toggles while a byte is in flight
    clear_log();
    x = 8'($urandom);
    fork
      begin put_byte(x, 1'b1); bus.tx_valid = 1'b0; end
    join_none
    wait_accept();
    t = (acc_t.size() > 0) ? acc_t[0] : -1000;
    @(posedge clk); #3 intn = 1'b0;
    @(posedge clk); #1 chk("E_irq_1edge", irq, 1'b0);
    @(posedge clk); #1 chk("E_irq_set", irq, 1'b1);
    #2 intn = 1'b1;
    @(posedge clk); #1 chk("E_irq_hold", irq, 1'b1);
    @(posedge clk); #1 chk("E_irq_clr", irq, 1'b0);
    @(negedge clk);
    idle_wait();
    chk("E_rx_data", rxv_d[0], x);
    chk("E_rxv_time", rxv_t[0], t + 1 + 16 * D);

    // Asynchronous reset mid-byte while sclk is high
    clear_log();
    x = 8'($urandom);
    fork
      begin put_byte(x, 1'b1); bus.tx_valid = 1'b0; end
    join_none
    wait_accept();
    t = (acc_t.size() > 0) ? acc_t[0] : -1000;
    n = 0;
    while (cyc < t + 1 + 5 * D && n < 100) begin @(posedge clk); #1; n++; end
    chk("F_sclk_pre", sclk, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("F_csn_async", csn, 1'b1);
    chk("F_sclk_async", sclk, 1'b0);
    chk("F_ready_async", bus.tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("F_no_rxv", rxv_t.size(), 0);
    chk("F_one_fall", fall_t.size(), 1);
    clear_log();
    x = 8'($urandom);
    put_byte(x, 1'b1);
    bus.tx_valid = 1'b0;
    idle_wait();
    t = (acc_t.size() > 0) ? acc_t[0] : -1000;
    chk("F_rx_after", rxv_d[0], x);
    chk("F_rxv_time", rxv_t[0], t + 1 + 16 * D);

    // CLK_DIV=1 instance, loopback
    for (int i = 0; i < 2; i++) begin
      clear_log();
      x = (i == 0) ? 8'h81 : 8'($urandom);
      bus1.tx_data  = x;
      bus1.tx_last  = 1'b1;
      bus1.tx_valid = 1'b1;
      @(negedge clk);
      bus1.tx_valid = 1'b0;
      repeat (40) @(negedge clk);
      t = (acc1_t.size() > 0) ? acc1_t[0] : -1000;
      chk("G_rxv_time", rxv1_t[0], t + 17);
      chk("G_rx_data", rxv1_d[0], x);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
